// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: digit moduli, FSM encoding
// and the per-digit load saturation helper.
package countdown_timer_pkg;

  localparam int unsigned SEC_ONES_L = 10;
  localparam int unsigned SEC_TENS_L = 6;
  localparam int unsigned MIN_ONES_L = 10;
  localparam int unsigned MIN_TENS_L = 6;

  localparam int unsigned ONES_W = $clog2(SEC_ONES_L);
  localparam int unsigned TENS_W = $clog2(SEC_TENS_L);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Clamp a loaded BCD digit to the largest legal value of a modulo-l digit.
  function automatic logic [3:0] sat_digit(input logic [3:0] d, input int unsigned l);
    return (d > 4'(l - 1)) ? 4'(l - 1) : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the key decoder, the timer and the digit renderers.
interface countdown_timer_if;
  logic        load;
  logic [15:0] load_val;
  logic        start_stop;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        done;

  modport master (
    output load, load_val, start_stop,
    input  digits, running, expired, done
  );

  modport slave (
    input  load, load_val, start_stop,
    output digits, running, expired, done
  );
endinterface

// File: rtl/countdown_timer_lim_dec.sv
// Modulo-L digit decrementor with borrow in/out; input is first clamped to L-1.
module lim_dec #(
  parameter int unsigned L = 10,
  parameter int unsigned N = $clog2(L)
) (
  input  logic [N-1:0] a,
  input  logic         bi,
  output logic [N-1:0] diff,
  output logic         bo
);

  logic [N-1:0] a_sat;

  always_comb begin
    a_sat = (a > N'(L - 1)) ? N'(L - 1) : a;
    diff  = a_sat;
    bo    = 1'b0;
    if (bi) begin
      if (a_sat == '0) begin
        diff = N'(L - 1);
        bo   = 1'b1;
      end else begin
        diff = a_sat - N'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: prescaled one-second ticks drive a borrow chain of
// modulo-L digit decrementors; stops and flags expiry at 00:00.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  state_e             state_q;
  logic [CNT_W-1:0]   presc_q;
  logic [ONES_W-1:0]  so_q, mo_q;
  logic [TENS_W-1:0]  st_q, mt_q;
  logic               running_q, expired_q, done_q;

  logic [ONES_W-1:0]  so_d, mo_d;
  logic [TENS_W-1:0]  st_d, mt_d;
  logic               so_bo, st_bo, mo_bo, mt_bo;
  logic               tick_c, cnt_zero_c, dec_zero_c;

  assign tick_c     = (state_q == RUN) && (presc_q == CNT_W'(TICK_DIV - 1));
  assign cnt_zero_c = ({mt_q, mo_q, st_q, so_q} == '0);
  assign dec_zero_c = ({mt_d, mo_d, st_d, so_d} == '0);

  // Borrow ripples seconds-ones -> seconds-tens -> minutes-ones -> minutes-tens.
  lim_dec #(.L(SEC_ONES_L)) u_so (.a(so_q), .bi(tick_c), .diff(so_d), .bo(so_bo));
  lim_dec #(.L(SEC_TENS_L)) u_st (.a(st_q), .bi(so_bo),  .diff(st_d), .bo(st_bo));
  lim_dec #(.L(MIN_ONES_L)) u_mo (.a(mo_q), .bi(st_bo),  .diff(mo_d), .bo(mo_bo));
  lim_dec #(.L(MIN_TENS_L)) u_mt (.a(mt_q), .bi(mo_bo),  .diff(mt_d), .bo(mt_bo));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      so_q      <= '0;
      st_q      <= '0;
      mo_q      <= '0;
      mt_q      <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        so_q      <= ONES_W'(sat_digit(bus.load_val[3:0],   SEC_ONES_L));
        st_q      <= TENS_W'(sat_digit(bus.load_val[7:4],   SEC_TENS_L));
        mo_q      <= ONES_W'(sat_digit(bus.load_val[11:8],  MIN_ONES_L));
        mt_q      <= TENS_W'(sat_digit(bus.load_val[15:12], MIN_TENS_L));
        state_q   <= IDLE;
        presc_q   <= '0;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, PAUSED: begin
            if (bus.start_stop && !cnt_zero_c) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (tick_c) begin
              presc_q <= '0;
              // A final borrow would mean wrapping below 00:00; never let it land.
              if (!mt_bo) begin
                so_q <= so_d;
                st_q <= st_d;
                mo_q <= mo_d;
                mt_q <= mt_d;
              end
              if (dec_zero_c) begin
                state_q   <= DONE;
                running_q <= 1'b0;
                expired_q <= 1'b1;
                done_q    <= 1'b1;
              end else if (bus.start_stop) begin
                state_q   <= PAUSED;
                running_q <= 1'b0;
              end
            end else begin
              presc_q <= presc_q + CNT_W'(1);
              if (bus.start_stop) begin
                state_q   <= PAUSED;
                running_q <= 1'b0;
              end
            end
          end
          DONE: ;
        endcase
      end
    end
  end

  assign bus.digits  = {1'b0, mt_q, mo_q, 1'b0, st_q, so_q};
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds-based reference model queues
// the expected outputs of every clock; a monitor pops and compares them.
module tb_countdown_timer;

  localparam int unsigned TD = 4;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  countdown_timer_if bus();

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        expired;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: remaining time kept as a plain number of seconds.
  int m_secs, m_st, m_presc;
  bit m_done;

  function automatic int clamp(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int bcd_to_secs(logic [15:0] v);
    int mt, mo, st, so;
    mt = clamp(int'(v[15:12]), 5);
    mo = clamp(int'(v[11:8]), 9);
    st = clamp(int'(v[7:4]), 5);
    so = clamp(int'(v[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] secs_to_bcd(int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs  = 0;
    m_st    = S_IDLE;
    m_presc = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(bit ld, logic [15:0] lv, bit ss);
    m_done = 1'b0;
    if (ld) begin
      m_secs  = bcd_to_secs(lv);
      m_st    = S_IDLE;
      m_presc = 0;
    end else if (m_st == S_IDLE || m_st == S_PAUSE) begin
      if (ss && m_secs != 0) m_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (m_presc == TD - 1) begin
        m_presc = 0;
        m_secs  = m_secs - 1;
        if (m_secs == 0) begin
          m_st   = S_DONE;
          m_done = 1'b1;
        end else if (ss) begin
          m_st = S_PAUSE;
        end
      end else begin
        m_presc = m_presc + 1;
        if (ss) m_st = S_PAUSE;
      end
    end
  endtask

  // Drive one clock's inputs and queue the outputs expected after that edge.
  task automatic cycle(bit ld, logic [15:0] lv, bit ss);
    exp_t e;
    @(negedge clk);
    bus.load       = ld;
    bus.load_val   = lv;
    bus.start_stop = ss;
    model_step(ld, lv, ss);
    e.digits  = secs_to_bcd(m_secs);
    e.running = (m_st == S_RUN);
    e.expired = (m_st == S_DONE);
    e.done    = m_done;
    sb_q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("digits",  int'(bus.digits),  int'(e.digits));
        chk("running", int'(bus.running), int'(e.running));
        chk("expired", int'(bus.expired), int'(e.expired));
        chk("done",    int'(bus.done),    int'(e.done));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] lv;
    bit          ld, ss;

    reset          = 1'b1;
    bus.load       = 1'b0;
    bus.load_val   = 16'h0000;
    bus.start_stop = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_digits",  int'(bus.digits),  0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_expired", int'(bus.expired), 0);
    chk("rst_done",    int'(bus.done),    0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset while running at 00:03.
    cycle(1'b1, 16'h0003, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrun_rst_digits",  int'(bus.digits),  0);
    chk("midrun_rst_running", int'(bus.running), 0);
    chk("midrun_rst_done",    int'(bus.done),    0);
    @(negedge clk);
    chk("midrun_rst_hold_done", int'(bus.done), 0);
    reset = 1'b0;
    model_reset();

    // Two plain decrements.
    cycle(1'b1, 16'h0102, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(8);

    // Borrow across all four digits.
    cycle(1'b1, 16'h1000, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(5);

    // Expiry, then start_stop ignored in DONE.
    cycle(1'b1, 16'h0001, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(5);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(2);

    // Saturation, then start with zero count.
    cycle(1'b1, 16'h7F9A, 1'b0);
    idle(1);
    cycle(1'b1, 16'h0000, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(2);

    // Pause mid-second and resume.
    cycle(1'b1, 16'h0005, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(2);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(10);
    cycle(1'b0, 16'h0000, 1'b1);
    idle(4);

    // load wins over a simultaneous start_stop.
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'h0042, 1'b1);
    idle(3);

    for (int i = 0; i < 800; i++) begin
      ld = ($urandom % 25) == 0;
      ss = ($urandom % 7) == 0;
      if (($urandom % 2) == 0) lv = 16'($urandom);
      else                     lv = {12'h000, 4'($urandom % 4)};
      cycle(ld, lv, ss);
    end
    idle(2);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- MM:SS countdown timer: the decrementing counterpart of the modulo-L incrementor chain that drives the up-counting clock display.
- Holds four BCD digits and decrements once per prescaled second through a borrow chain of modulo-L decrementors.
- Stops and flags expiry at 00:00.
- Feeds the 7-segment and VGA digit renderers; controlled by debounced one-cycle pulses from the PS2 key decoder.

Parameters:
- TICK_DIV, 100000000, clk cycles per decrement (one second at 100 MHz); must be >= 2.
- CNT_W, $clog2(TICK_DIV), prescaler width (derived, not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  one-cycle pulse: capture load_val
- load_val  in  16  {m_tens, m_ones, s_tens, s_ones}, 4 bits per digit
- start_stop  in  1  one-cycle pulse: toggle run/pause
- digits  out  16  current count, same packing as load_val
- running  out  1  high in RUN state
- expired  out  1  level, high in DONE state
- done  out  1  one-cycle pulse on reaching 00:00

Behaviour:
- One clock, clk. Reset is asynchronous, active-high.
- Reset values: digits=0, state=IDLE, prescaler=0, running=0, expired=0, done=0.
- Reset mid-run aborts immediately; no done pulse is generated.
- States:
  - IDLE: loaded but not started.
  - RUN: counting.
  - PAUSED: halted mid-count.
  - DONE: reached 00:00.
- load, in any state:
  - Digits are saturated per digit: m_tens, s_tens > 5 -> 5; m_ones, s_ones > 9 -> 9.
  - Saturated value registered into digits on the next edge.
  - state -> IDLE, prescaler -> 0, expired -> 0.
- load and start_stop in the same cycle: load wins, start_stop is dropped.
- start_stop:
  - In IDLE or PAUSED with digits != 0 -> RUN.
  - In IDLE or PAUSED with digits == 0 -> no change.
  - In RUN -> PAUSED.
  - In DONE -> ignored.
- Prescaler:
  - Increments only in RUN; holds its value in PAUSED, so a resumed second continues from where it stopped.
  - At TICK_DIV-1: wraps to 0 and asserts the internal tick for that cycle.
- On tick:
  - digits <= decremented value on the same edge.
  - Borrow chain: s_ones mod 10 -> s_tens mod 6 -> m_ones mod 10 -> m_tens mod 6.
  - Example: 10:00 -> 09:59.
  - If the decremented value is 00:00: state -> DONE, done=1 for exactly that one cycle (registered, coincident with digits first showing 0000), expired=1 until the next load or reset.
- Latency:
  - load -> digits: 1 cycle.
  - start_stop -> running: 1 cycle.
  - First decrement occurs TICK_DIV cycles after RUN is entered from a zero prescaler.
- Pausing on the same cycle as a tick: the tick's decrement still applies, then state -> PAUSED.
- Wrap below 00:00 never occurs; DONE freezes the count.
- Only the maximum 59:59 is reachable.

Decomposition:
- Shared package:
  - Digit moduli localparams: SEC_ONES_L=10, SEC_TENS_L=6, MIN_ONES_L=10, MIN_TENS_L=6.
  - State encoding: IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3.
- Sub-module lim_dec (parameter L, N=$clog2(L)), combinational:
  - Inputs a[N-1:0], bi. Outputs diff[N-1:0], bo.
  - a is first saturated at L-1.
  - bi=0 -> diff=a_sat, bo=0.
  - bi=1 and a_sat=0 -> diff=L-1, bo=1.
  - Otherwise diff=a_sat-1, bo=0.
  - Four instances chained borrow-to-borrow; bi of the first instance is tied to tick.
- Top-level register instance: one always block for the FSM, prescaler and digits.

Test Plan (TICK_DIV=4):
- Reset asserted mid-RUN at 00:03 -> digits=0000, running=0, state IDLE on the same cycle; no done pulse.
- load 0x0102, start_stop, 8 clocks -> digits 0x0101 after 4 cycles, 0x0100 after 8; running=1 throughout.
- load 0x1000, start, 4 clocks -> digits 0x0959 (borrow crosses all four digits).
- load 0x0001, start, 4 clocks -> digits 0x0000, done high exactly 1 cycle, expired=1, running=0; further start_stop ignored.
- load 0x7F9A -> digits 0x5959 (saturation); load 0x0000 then start_stop -> stays IDLE, running=0.
- RUN 2 cycles into a second, start_stop (pause) for 10 cycles, start_stop (resume) -> decrement 2 cycles after resume. Separately, load+start_stop in the same cycle -> IDLE with the new value.
